// File: rtl/a2d_scan_ctrl_pkg.sv
// Shared types and helpers for the A2D round-robin scan controller.
package a2d_scan_ctrl_pkg;

  localparam int CH_W  = 3;
  localparam int RES_W = 12;
  localparam int CMD_W = 16;
  localparam int RD_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT_C,
    RD,
    WAIT_R,
    STORE,
    GAP
  } state_t;

  // Channel-select command word understood by the A2D.
  function automatic logic [CMD_W-1:0] a2d_cmd(input logic [CH_W-1:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_scan_ctrl_if.sv
// Handshake between the scan controller and the SPI master.
interface a2d_scan_ctrl_if;
  import a2d_scan_ctrl_pkg::*;

  logic             spi_wrt;
  logic [CMD_W-1:0] spi_cmd;
  logic             spi_done;
  logic [RD_W-1:0]  spi_rd;

  modport master (output spi_wrt, output spi_cmd, input spi_done, input spi_rd);
  modport slave  (input spi_wrt, input spi_cmd, output spi_done, output spi_rd);

endinterface

// File: rtl/a2d_scan_ctrl_gap_timer.sv
// 16-bit down-counter timing the idle gap between scans.
// Holds at zero unless loaded; never wraps.
module a2d_scan_ctrl_gap_timer #(
  parameter logic [15:0] LOAD_VAL = 16'd1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  input  logic clr,
  output logic last,
  output logic zero
);

  logic [15:0] cnt;

  // Clear wins over load, load wins over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != 16'd0)) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign last = (cnt == 16'd1);
  assign zero = (cnt == 16'd0);

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Round-robin scan of NUM_CH A2D channels through the SPI master.
// Each channel: select command, read-back, then store the 12-bit result.
//
//  state  | meaning
//  IDLE   | scanning disabled, waiting for en
//  CMD    | issue channel-select transaction
//  WAIT_C | wait for fresh done edge of the select
//  RD     | issue read-back transaction (same command)
//  WAIT_R | wait for fresh done edge of the read-back
//  STORE  | latch result, advance channel or finish scan
//  GAP    | idle gap between scans
module a2d_scan_ctrl
  import a2d_scan_ctrl_pkg::*;
#(
  parameter int          NUM_CH   = 5,
  parameter logic [15:0] SCAN_GAP = 16'd1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  a2d_scan_ctrl_if.master   spi,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [RES_W-1:0]  rd_val,
  output logic [NUM_CH-1:0] ch_valid,
  output logic              scan_done
);

  localparam int             NUM_SLOTS = 1 << CH_W;
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   NUM_CH_V = (CH_W + 1)'(NUM_CH);

  state_t            state;
  logic [CH_W-1:0]   ch;
  logic              spi_done_q;
  logic              done_rise;
  logic [RES_W-1:0]  res [NUM_SLOTS];
  logic              gap_load;
  logic              gap_dec;
  logic              gap_clr;
  logic              gap_last;
  logic              gap_zero;
  logic              unused_rd_hi;

  // Only the low 12 bits of the read-back carry the conversion.
  assign unused_rd_hi = ^spi.spi_rd[RD_W-1:RES_W];

  // Delay spi_done so a level left high from an earlier transfer is not seen as completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_done_q <= 1'b0;
    end else begin
      spi_done_q <= spi.spi_done;
    end
  end

  assign done_rise = spi.spi_done & ~spi_done_q;

  assign gap_load = (state == STORE) && (ch == LAST_CH);
  assign gap_dec  = (state == GAP) && en;
  assign gap_clr  = (state == GAP) && !en;

  a2d_scan_ctrl_gap_timer #(
    .LOAD_VAL(SCAN_GAP)
  ) u_gap_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (gap_load),
    .dec  (gap_dec),
    .clr  (gap_clr),
    .last (gap_last),
    .zero (gap_zero)
  );

  // Sequencing FSM with registered SPI strobe, command, scan_done and valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= '0;
      spi.spi_wrt <= 1'b0;
      spi.spi_cmd <= '0;
      scan_done   <= 1'b0;
      ch_valid    <= '0;
    end else begin
      spi.spi_wrt <= 1'b0;
      scan_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            ch    <= '0;
            state <= CMD;
          end
        end
        CMD: begin
          spi.spi_cmd <= a2d_cmd(ch);
          spi.spi_wrt <= 1'b1;
          state       <= WAIT_C;
        end
        WAIT_C: begin
          if (done_rise) state <= RD;
        end
        RD: begin
          spi.spi_wrt <= 1'b1;
          state       <= WAIT_R;
        end
        WAIT_R: begin
          if (done_rise) state <= STORE;
        end
        STORE: begin
          ch_valid[ch] <= 1'b1;
          if (ch == LAST_CH) begin
            scan_done <= 1'b1;
            ch        <= '0;
            state     <= GAP;
          end else if (en) begin
            ch    <= ch + 3'd1;
            state <= CMD;
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          // Leave on the edge the counter reaches zero, giving exactly SCAN_GAP idle clocks.
          if (!en) begin
            state <= IDLE;
          end else if (gap_last || gap_zero) begin
            state <= CMD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-channel result register file, written once per conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        res[i] <= '0;
      end
    end else if (state == STORE) begin
      res[ch] <= spi.spi_rd[RES_W-1:0];
    end
  end

  assign rd_val = ({1'b0, rd_ch} < NUM_CH_V) ? res[rd_ch] : '0;

endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// Directed bench for a2d_scan_ctrl with a behavioural SPI master / A2D model
// that returns 12'h100 + channel after a fixed transfer time.
module tb_a2d_scan_ctrl;
  import a2d_scan_ctrl_pkg::*;

  localparam int          NUM_CH = 5;
  localparam logic [15:0] GAP    = 16'd10;
  localparam int          XFER   = 4;
  localparam int          CH_CLKS = 2 * (XFER + 1) + 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  rd_ch = 3'd0;
  logic [11:0] rd_val;
  logic [4:0]  ch_valid;
  logic        scan_done;
  logic        stale_req = 1'b0;

  int total = 0;
  int bad = 0;

  a2d_scan_ctrl_if spi ();

  a2d_scan_ctrl #(
    .NUM_CH  (NUM_CH),
    .SCAN_GAP(GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .spi      (spi),
    .rd_ch    (rd_ch),
    .rd_val   (rd_val),
    .ch_valid (ch_valid),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // SPI master + A2D model: done clears on wrt, rises XFER clks later with the result.
  int       m_cnt;
  logic [2:0] m_ch;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi.spi_done <= 1'b0;
      spi.spi_rd   <= '0;
      m_cnt        <= 0;
      m_ch         <= '0;
    end else if (spi.spi_wrt) begin
      spi.spi_done <= 1'b0;
      m_cnt        <= XFER;
      m_ch         <= spi.spi_cmd[13:11];
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        spi.spi_done <= 1'b1;
        spi.spi_rd   <= {4'hA, 4'h1, 5'h00, m_ch};
      end
    end else if (stale_req) begin
      spi.spi_done <= 1'b1;
    end
  end

  // Cycle counter and passive monitor of strobes.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wrt_q[$];
  int wrt_cyc_last = 0;
  int sd_cyc_last = 0;
  int sd_count = 0;
  int sd_wide = 0;
  int proto_err = 0;
  logic sd_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && spi.spi_wrt) begin
      wrt_q.push_back(spi.spi_cmd);
      wrt_cyc_last = cyc;
      if (m_cnt != 0) proto_err++;
    end
    if (rst_n && scan_done) begin
      sd_cyc_last = cyc;
      sd_count++;
      if (sd_prev) sd_wide++;
    end
    sd_prev = rst_n && scan_done;
  end

  task automatic wait_wrts(input int n, input int budget, input string tag);
    int k = 0;
    while (wrt_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (wrt_q.size() < n) begin
      bad++;
      $display("FAIL %s: wrt count %0d, required %0d within %0d clks", tag, wrt_q.size(), n, budget);
    end
  endtask

  task automatic wait_sd(input int n, input int budget, input string tag);
    int k = 0;
    while (sd_count < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (sd_count < n) begin
      bad++;
      $display("FAIL %s: scan_done count %0d, required %0d within %0d clks", tag, sd_count, n, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    stale_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (spi.spi_wrt !== 1'b0) begin bad++; $display("FAIL rst_wrt: got %b want 0", spi.spi_wrt); end
    total++; if (spi.spi_cmd !== 16'h0000) begin bad++; $display("FAIL rst_cmd: got %h want 0000", spi.spi_cmd); end
    total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL rst_scan_done: got %b want 0", scan_done); end
    total++; if (ch_valid !== 5'h00) begin bad++; $display("FAIL rst_ch_valid: got %h want 00", ch_valid); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want IDLE", dut.state); end
    for (int i = 0; i < NUM_CH; i++) begin
      rd_ch = 3'(i);
      #1;
      total++; if (rd_val !== 12'h000) begin bad++; $display("FAIL rst_rd_val ch%0d: got %h want 000", i, rd_val); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int base, sd0, c0;
    logic [2:0]  c;
    logic [15:0] exp;
    base = wrt_q.size();
    sd0 = sd_count;
    @(negedge clk);
    en = 1'b1;
    c0 = cyc;
    wait_sd(sd0 + 1, 300, "scan_first_done");
    en = 1'b0;
    // One extra clk for the IDLE->CMD decision before the per-channel cost.
    total++; if (sd_cyc_last - c0 !== 1 + NUM_CH * CH_CLKS) begin bad++; $display("FAIL scan_latency: got %0d want %0d", sd_cyc_last - c0, 1 + NUM_CH * CH_CLKS); end
    total++; if (wrt_q.size() - base !== 2 * NUM_CH) begin bad++; $display("FAIL scan_wrt_count: got %0d want %0d", wrt_q.size() - base, 2 * NUM_CH); end
    for (int i = 0; i < 2 * NUM_CH; i++) begin
      c = 3'(i / 2);
      exp = {2'b00, c, 11'h000};
      total++; if (wrt_q[base + i] !== exp) begin bad++; $display("FAIL scan_cmd[%0d]: got %h want %h", i, wrt_q[base + i], exp); end
    end
    total++; if (ch_valid !== 5'h1F) begin bad++; $display("FAIL scan_ch_valid: got %h want 1f", ch_valid); end
    for (int i = 0; i < NUM_CH; i++) begin
      rd_ch = 3'(i);
      #1;
      total++; if (rd_val !== 12'(12'h100 + i)) begin bad++; $display("FAIL scan_rd_val ch%0d: got %h want %h", i, rd_val, 12'(12'h100 + i)); end
    end
    repeat (30) @(negedge clk);
    total++; if (wrt_q.size() - base !== 2 * NUM_CH) begin bad++; $display("FAIL scan_stop_in_gap: got %0d wrts want %0d", wrt_q.size() - base, 2 * NUM_CH); end
    total++; if (sd_wide !== 0) begin bad++; $display("FAIL scan_done_width: got %0d wide pulses want 0", sd_wide); end
    total++; if (proto_err !== 0) begin bad++; $display("FAIL scan_protocol: got %0d overlapping wrts want 0", proto_err); end
  endtask

  task automatic test_stale_done();
    int base, c0, k, cv_cyc, p0;
    do_reset();
    base = wrt_q.size();
    p0 = proto_err;
    stale_req = 1'b1;
    @(negedge clk);
    stale_req = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (spi.spi_done !== 1'b1) begin bad++; $display("FAIL stale_setup: spi_done got %b want 1", spi.spi_done); end
    en = 1'b1;
    c0 = cyc;
    wait_wrts(base + 2, 60, "stale_rd_wrt");
    en = 1'b0;
    k = 0;
    while (ch_valid[0] !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    cv_cyc = cyc;
    total++; if (cv_cyc - c0 !== 1 + CH_CLKS) begin bad++; $display("FAIL stale_store_time: got %0d want %0d", cv_cyc - c0, 1 + CH_CLKS); end
    total++; if (wrt_q.size() - base !== 2) begin bad++; $display("FAIL stale_wrt_count: got %0d want 2", wrt_q.size() - base); end
    rd_ch = 3'd0;
    #1;
    total++; if (rd_val !== 12'h100) begin bad++; $display("FAIL stale_rd_val: got %h want 100", rd_val); end
    total++; if (proto_err - p0 !== 0) begin bad++; $display("FAIL stale_protocol: got %0d overlapping wrts want 0", proto_err - p0); end
    repeat (20) @(negedge clk);
    total++; if (wrt_q.size() - base !== 2) begin bad++; $display("FAIL stale_no_more_wrt: got %0d want 2", wrt_q.size() - base); end
    total++; if (ch_valid !== 5'h01) begin bad++; $display("FAIL stale_ch_valid: got %h want 01", ch_valid); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL stale_idle: got %0d want IDLE", dut.state); end
  endtask

  task automatic test_en_drop();
    int base, k;
    do_reset();
    base = wrt_q.size();
    @(negedge clk);
    en = 1'b1;
    wait_wrts(base + 5, 200, "drop_ch2_cmd");
    total++; if (wrt_q[base + 4] !== 16'h1000) begin bad++; $display("FAIL drop_ch2_cmd_word: got %h want 1000", wrt_q[base + 4]); end
    en = 1'b0;
    k = 0;
    while (ch_valid !== 5'h07 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    total++; if (ch_valid !== 5'h07) begin bad++; $display("FAIL drop_ch_valid: got %h want 07", ch_valid); end
    total++; if (wrt_q.size() - base !== 6) begin bad++; $display("FAIL drop_wrt_count: got %0d want 6", wrt_q.size() - base); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL drop_idle: got %0d want IDLE", dut.state); end
    rd_ch = 3'd2;
    #1;
    total++; if (rd_val !== 12'h102) begin bad++; $display("FAIL drop_rd_ch2: got %h want 102", rd_val); end
    rd_ch = 3'd3;
    #1;
    total++; if (rd_val !== 12'h000) begin bad++; $display("FAIL drop_rd_ch3: got %h want 000", rd_val); end
    @(negedge clk);
    en = 1'b1;
    wait_wrts(base + 7, 20, "drop_restart");
    total++; if (wrt_q[base + 6] !== 16'h0000) begin bad++; $display("FAIL drop_restart_cmd: got %h want 0000", wrt_q[base + 6]); end
  endtask

  task automatic test_gap();
    int base, sd0, s;
    sd0 = sd_count;
    wait_sd(sd0 + 1, 300, "gap_scan_done");
    s = sd_cyc_last;
    base = wrt_q.size();
    wait_wrts(base + 1, 30, "gap_next_wrt");
    total++; if (wrt_cyc_last - s !== int'(GAP) + 1) begin bad++; $display("FAIL gap_spacing: got %0d want %0d", wrt_cyc_last - s, int'(GAP) + 1); end
    total++; if (wrt_q[base] !== 16'h0000) begin bad++; $display("FAIL gap_next_cmd: got %h want 0000", wrt_q[base]); end
    total++; if (ch_valid !== 5'h1F) begin bad++; $display("FAIL gap_ch_valid: got %h want 1f", ch_valid); end
    wait_sd(sd0 + 2, 300, "gap_second_done");
    repeat (3) @(negedge clk);
    base = wrt_q.size();
    en = 1'b0;
    repeat (30) @(negedge clk);
    total++; if (wrt_q.size() !== base) begin bad++; $display("FAIL gap_en_drop_wrt: got %0d wrts want %0d", wrt_q.size(), base); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL gap_en_drop_idle: got %0d want IDLE", dut.state); end
  endtask

  task automatic test_rd_mux();
    logic [2:0]  v;
    logic [11:0] exp;
    for (int i = 5; i < 8; i++) begin
      rd_ch = 3'(i);
      #1;
      total++; if (rd_val !== 12'h000) begin bad++; $display("FAIL rdmux_oob ch%0d: got %h want 000", i, rd_val); end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v = 3'((k * 3 + 1) % 8);
      rd_ch = v;
      exp = (v < 3'd5) ? 12'(12'h100 + v) : 12'h000;
      #1;
      total++; if (rd_val !== exp) begin bad++; $display("FAIL rdmux_track ch%0d: got %h want %h", v, rd_val, exp); end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = wrt_q.size();
    rd_ch = 3'd4;
    @(negedge clk);
    en = 1'b1;
    wait_wrts(base + 4, 100, "rstmid_ch1_rd");
    @(negedge clk);
    total++; if (spi.spi_cmd !== 16'h0800) begin bad++; $display("FAIL rstmid_pre_cmd: got %h want 0800", spi.spi_cmd); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (spi.spi_wrt !== 1'b0) begin bad++; $display("FAIL rstmid_wrt: got %b want 0", spi.spi_wrt); end
    total++; if (spi.spi_cmd !== 16'h0000) begin bad++; $display("FAIL rstmid_cmd: got %h want 0000", spi.spi_cmd); end
    total++; if (scan_done !== 1'b0) begin bad++; $display("FAIL rstmid_scan_done: got %b want 0", scan_done); end
    total++; if (ch_valid !== 5'h00) begin bad++; $display("FAIL rstmid_ch_valid: got %h want 00", ch_valid); end
    total++; if (rd_val !== 12'h000) begin bad++; $display("FAIL rstmid_rd_val: got %h want 000", rd_val); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rstmid_state: got %0d want IDLE", dut.state); end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base = wrt_q.size();
    repeat (10) @(negedge clk);
    total++; if (wrt_q.size() !== base) begin bad++; $display("FAIL rstmid_no_orphan: got %0d wrts want %0d", wrt_q.size(), base); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_stale_done();
    test_en_drop();
    test_gap();
    test_rd_mux();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
